bus_arbiter: RTL and testbench

//  Round-robin scheduler for a shared broadcast bus fed by per-driver FIFOs (width=16, depth=8 class).

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 119 +++++++++++
 tb/tb_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the broadcast-bus arbiter.
// Holds the FSM encoding, the broadcast ID default and the destination-ID extractor.
package bus_arb_pkg;

  typedef enum logic {IDLE, SEND} arb_state_t;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BC_ID_DEFAULT = 8'hFF;

  // Destination ID lives in the top ID_W bits of a w-bit packet.
  function automatic logic [ID_W-1:0] id_of(input logic [63:0] pkt, input int w);
    return ID_W'(pkt >> (w - ID_W));
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, wrapping.
// Zero latency; valid is low when no request is pending.
module rr_picker #(
  parameter int n  = 4,
  parameter int lw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [lw-1:0] last,
  output logic [lw-1:0] idx,
  output logic          valid
);

  logic          found;
  logic [lw-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= n; i++) begin
      cand = lw'((int'(last) + i) % n);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus master: grant/pop at edge N, push at N+1, so 2 cycles per packet minimum.
// Stalls while any target FIFO is full; BUS_ARB_WATCHDOG_EN adds a stall timeout with drop pulse.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              drvrs   = 4,
  parameter int              width   = 16,
  parameter logic [ID_W-1:0] bc_id   = BC_ID_DEFAULT,
  parameter int              timeout = 16,
  localparam int             GW      = $clog2(drvrs)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [drvrs-1:0]       pndng_i,
  input  logic [drvrs*width-1:0] dato_i,
  output logic [drvrs-1:0]       pop_o,
  input  logic [drvrs-1:0]       full_i,
  output logic [drvrs-1:0]       push_o,
  output logic [width-1:0]       bus_o,
  output logic [GW-1:0]          grant_o,
  output logic                   busy_o,
  output logic                   drop_o
);

  localparam logic [drvrs-1:0] ONE = drvrs'(1);

  arb_state_t       state;
  logic [GW-1:0]    pick_idx;
  logic             pick_vld;
  logic [ID_W-1:0]  id;
  logic [drvrs-1:0] mask;
  logic             stall;

  rr_picker #(.n(drvrs), .lw(GW)) u_pick (
    .req   (pndng_i),
    .last  (grant_o),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // Target set is derived from the latched packet, so it stays stable across a stall.
  always_comb begin
    id   = id_of(64'(bus_o), width);
    mask = '0;
    if (id == bc_id)
      mask = ~(ONE << grant_o);
    else if (int'(id) < drvrs)
      mask = ONE << id;
    stall = |(mask & full_i);
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int CW = $clog2(timeout + 1);
  logic [CW-1:0] stall_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pop_o   <= '0;
      push_o  <= '0;
      bus_o   <= '0;
      busy_o  <= 1'b0;
      grant_o <= GW'(drvrs - 1);
`ifdef BUS_ARB_WATCHDOG_EN
      drop_o    <= 1'b0;
      stall_cnt <= '0;
`endif
    end else begin
      pop_o  <= '0;
      push_o <= '0;
`ifdef BUS_ARB_WATCHDOG_EN
      drop_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_o <= pick_idx;
            bus_o   <= dato_i[int'(pick_idx)*width +: width];
            pop_o   <= ONE << pick_idx;
            busy_o  <= 1'b1;
            state   <= SEND;
`ifdef BUS_ARB_WATCHDOG_EN
            stall_cnt <= '0;
`endif
          end
        end
        SEND: begin
          if (mask == '0) begin
            busy_o <= 1'b0;
            state  <= IDLE;
`ifdef BUS_ARB_WATCHDOG_EN
            drop_o <= 1'b1;
`endif
          end else if (!stall) begin
            push_o <= mask;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
`ifdef BUS_ARB_WATCHDOG_EN
          else if (stall_cnt == CW'(timeout - 1)) begin
            drop_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_ARB_WATCHDOG_EN
  assign drop_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (drvrs=4, width=16): directed scenarios plus randomized packets vs. a transaction model.
module tb_bus_arbiter;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pndng, full, pop, push;
  logic [63:0] dato;
  logic [15:0] bus;
  logic [1:0]  grant;
  logic        busy, drop;

  int vecs = 0;
  int errs = 0;
  int last_g;

  bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pndng_i(pndng), .dato_i(dato), .pop_o(pop),
    .full_i(full), .push_o(push), .bus_o(bus), .grant_o(grant), .busy_o(busy), .drop_o(drop)
  );

  always #5 clk = ~clk;

  // Model: round-robin search from the previous grant.
  function automatic int pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++)
      if (req[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  // Model: which receivers a packet reaches when sent by driver g.
  function automatic logic [3:0] tgt(input logic [15:0] w, input int g);
    logic [7:0] id;
    id = w[15:8];
    if (id == 8'hFF) return 4'hF & ~(4'b0001 << g);
    if (id < 8'd4)   return 4'b0001 << id;
    return 4'b0000;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; pndng = '0; full = '0; dato = '0;
    repeat (2) @(negedge clk);
    vecs++; if (pop !== 4'b0)    begin errs++; $display("FAIL reset_pop got %b want 0000", pop); end
    vecs++; if (push !== 4'b0)   begin errs++; $display("FAIL reset_push got %b want 0000", push); end
    vecs++; if (bus !== 16'h0)   begin errs++; $display("FAIL reset_bus got %h want 0000", bus); end
    vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (drop !== 1'b0)   begin errs++; $display("FAIL reset_drop got %b want 0", drop); end
    vecs++; if (grant !== 2'd3)  begin errs++; $display("FAIL reset_grant got %0d want 3", grant); end
    rst_n = 1'b1;
    last_g = 3;
    @(negedge clk);
  endtask

  task automatic test_unicast;
    pndng = 4'b0010; dato[16 +: 16] = 16'h0255; full = '0;
    @(negedge clk);
    vecs++; if (pop !== 4'b0010) begin errs++; $display("FAIL uni_pop got %b want 0010", pop); end
    vecs++; if (grant !== 2'd1)  begin errs++; $display("FAIL uni_grant got %0d want 1", grant); end
    vecs++; if (bus !== 16'h0255) begin errs++; $display("FAIL uni_bus got %h want 0255", bus); end
    vecs++; if (busy !== 1'b1)   begin errs++; $display("FAIL uni_busy got %b want 1", busy); end
    pndng = '0;
    @(negedge clk);
    vecs++; if (pop !== 4'b0000)  begin errs++; $display("FAIL uni_pop_once got %b want 0000", pop); end
    vecs++; if (push !== 4'b0100) begin errs++; $display("FAIL uni_push got %b want 0100", push); end
    @(negedge clk);
    vecs++; if (push !== 4'b0000) begin errs++; $display("FAIL uni_push_once got %b want 0000", push); end
    last_g = 1;
  endtask

  task automatic test_broadcast;
    pndng = 4'b0001; dato[0 +: 16] = 16'hFFAB;
    @(negedge clk);
    vecs++; if (grant !== 2'd0 || pop !== 4'b0001) begin errs++; $display("FAIL bc_grant got %0d/%b want 0/0001", grant, pop); end
    pndng = '0;
    @(negedge clk);
    vecs++; if (push !== 4'b1110) begin errs++; $display("FAIL bc_push got %b want 1110", push); end
    vecs++; if (bus !== 16'hFFAB) begin errs++; $display("FAIL bc_bus got %h want FFAB", bus); end
    last_g = 0;
  endtask

  task automatic test_round_robin;
    int seq [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pndng = 4'b1111;
    for (int k = 0; k < 4; k++) dato[k*16 +: 16] = {8'h00, 8'(k)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (grant !== 2'(seq[i]) || pop !== (4'b0001 << seq[i])) begin
        errs++; $display("FAIL rr_grant%0d got %0d/%b want %0d", i, grant, pop, seq[i]);
      end
      @(negedge clk);
      vecs++;
      if (pop !== 4'b0 || push !== 4'b0001) begin
        errs++; $display("FAIL rr_push%0d got pop %b push %b want 0000/0001", i, pop, push);
      end
      if (i == 4) pndng = '0;
    end
    last_g = 0;
  endtask

  task automatic test_backpressure;
    pndng = 4'b0100; dato[32 +: 16] = 16'h0312; full = 4'b1000;
    @(negedge clk);
    vecs++; if (grant !== 2'd2 || bus !== 16'h0312) begin errs++; $display("FAIL bp_grant got %0d/%h want 2/0312", grant, bus); end
    pndng = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (push !== 4'b0 || bus !== 16'h0312 || busy !== 1'b1) begin
        errs++; $display("FAIL bp_stall%0d got push %b bus %h busy %b", i, push, bus, busy);
      end
    end
    full = '0;
    @(negedge clk);
    vecs++; if (push !== 4'b1000) begin errs++; $display("FAIL bp_push got %b want 1000", push); end
    @(negedge clk);
    vecs++; if (push !== 4'b0 || bus !== 16'h0312) begin errs++; $display("FAIL bp_after got %b/%h want 0000/0312", push, bus); end
    last_g = 2;
  endtask

  task automatic test_invalid_id;
    pndng = 4'b1000; dato[48 +: 16] = 16'h07CC;
    @(negedge clk);
    vecs++; if (grant !== 2'd3) begin errs++; $display("FAIL inv_grant got %0d want 3", grant); end
    pndng = '0;
    @(negedge clk);
    vecs++;
    if (push !== 4'b0 || busy !== 1'b0 || drop !== WD) begin
      errs++; $display("FAIL inv_drop got push %b busy %b drop %b want 0000/0/%b", push, busy, drop, WD);
    end
    @(negedge clk);
    vecs++; if (drop !== 1'b0 || push !== 4'b0) begin errs++; $display("FAIL inv_after got drop %b push %b", drop, push); end
    last_g = 3;
  endtask

  task automatic test_reset_mid_send;
    pndng = 4'b0001; dato[0 +: 16] = 16'h0312; full = 4'b1000;
    @(negedge clk);
    vecs++; if (busy !== 1'b1 || grant !== 2'd0) begin errs++; $display("FAIL rst_mid_setup got busy %b grant %0d", busy, grant); end
    pndng = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (pop !== 4'b0 || push !== 4'b0 || bus !== 16'h0 || busy !== 1'b0 || drop !== 1'b0 || grant !== 2'd3) begin
      errs++; $display("FAIL rst_mid_async got pop %b push %b bus %h busy %b drop %b grant %0d", pop, push, bus, busy, drop, grant);
    end
    @(negedge clk);
    rst_n = 1'b1; full = '0; pndng = 4'b1111;
    for (int k = 0; k < 4; k++) dato[k*16 +: 16] = 16'h0100 + 16'(k);
    @(negedge clk);
    vecs++; if (grant !== 2'd0 || pop !== 4'b0001) begin errs++; $display("FAIL rst_mid_first got %0d/%b want 0/0001", grant, pop); end
    pndng = '0;
    @(negedge clk);
    vecs++; if (push !== 4'b0010 || bus !== 16'h0100) begin errs++; $display("FAIL rst_mid_push got %b/%h want 0010/0100", push, bus); end
    last_g = 0;
  endtask

  task automatic test_watchdog;
    bit early = 1'b0;
    pndng = 4'b0100; dato[32 +: 16] = 16'h0233; full = 4'b0100;
    @(negedge clk);
    pndng = '0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (drop !== 1'b0 || push !== 4'b0) early = 1'b1;
    end
    vecs++; if (early) begin errs++; $display("FAIL wd_early got drop before 16 stalls want none"); end
    @(negedge clk);
    vecs++;
    if (drop !== 1'b1 || push !== 4'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL wd_drop got drop %b push %b busy %b want 1/0000/0", drop, push, busy);
    end
    full = '0;
    @(negedge clk);
    last_g = 2;
  endtask

  task automatic test_random;
    logic [15:0] w [4];
    logic [3:0]  m, req;
    int          g, k, r;
    for (int n = 0; n < 60; n++) begin
      req = 4'($urandom_range(1, 15));
      for (int d = 0; d < 4; d++) begin
        r = $urandom_range(0, 5);
        if (r < 4)       w[d] = {8'(r), 8'($urandom)};
        else if (r == 4) w[d] = {8'hFF, 8'($urandom)};
        else             w[d] = {8'($urandom_range(4, 254)), 8'($urandom)};
        dato[d*16 +: 16] = w[d];
      end
      pndng = req;
      full  = 4'($urandom);
      g = pick(req, last_g);
      m = tgt(w[g], g);
      @(negedge clk);
      vecs++;
      if (grant !== 2'(g) || pop !== (4'b0001 << g) || bus !== w[g] || push !== 4'b0) begin
        errs++; $display("FAIL rnd%0d_grant got %0d/%b/%h want %0d/%h", n, grant, pop, bus, g, w[g]);
      end
      last_g = g;
      pndng = 4'($urandom);
      if (m == 4'b0) begin
        @(negedge clk);
        vecs++;
        if (push !== 4'b0 || busy !== 1'b0 || drop !== WD) begin
          errs++; $display("FAIL rnd%0d_inv got push %b busy %b drop %b", n, push, busy, drop);
        end
      end else begin
        if ((m & full) != 4'b0) begin
          k = $urandom_range(1, 4);
          for (int j = 0; j < k; j++) begin
            @(negedge clk);
            vecs++;
            if (push !== 4'b0 || busy !== 1'b1 || bus !== w[g]) begin
              errs++; $display("FAIL rnd%0d_stall got push %b busy %b bus %h", n, push, busy, bus);
            end
          end
        end
        full = 4'($urandom) & ~m;
        @(negedge clk);
        vecs++;
        if (push !== m || busy !== 1'b0 || bus !== w[g]) begin
          errs++; $display("FAIL rnd%0d_push got %b busy %b want %b", n, push, busy, m);
        end
      end
      pndng = '0;
    end
    full = '0;
  endtask

  initial begin
    test_reset;
    test_unicast;
    test_broadcast;
    test_round_robin;
    test_backpressure;
    test_invalid_id;
    test_reset_mid_send;
    if (WD) test_watchdog;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
